enc_8_3_stream: RTL and testbench

- Sequential 8-to-3 priority encoder; the inverse companion of the team's 3-to-8 decoder.
- Accepts an 8-bit request vector on an input valid/ready handshake and latches it.
- Emits the 3-bit index of every set bit, one per output handshake, highest index first.
- Sits between request collectors (interrupt/lane masks) and downstream logic that consumes one binary code at a time.

---
 rtl/enc_8_3_stream_pkg.sv | 22 ++
 rtl/enc_8_3_stream_if.sv | 29 ++
 rtl/enc_8_3_stream_prio_enc_n.sv | 23 ++
 rtl/enc_8_3_stream.sv | 89 ++++++++
 tb/tb_enc_8_3_stream.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/enc_8_3_stream_pkg.sv
// rtl/enc_8_3_stream_pkg.sv - shared types, default widths and popcount helper
package enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int N_DEF  = 8;
  localparam int CW_DEF = 3;

  // Counts set bits; callers zero-extend their vector to 32 bits.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/enc_8_3_stream_if.sv
// rtl/enc_8_3_stream_if.sv - request/code handshake bundle for the stream encoder
interface enc_8_3_stream_if
  import enc_pkg::*;
#(
  parameter int N = N_DEF
);
  localparam int CW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  req;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] y;
  logic          out_last;
  logic [CW:0]   cnt;
  logic          zero_err;

  modport slave (
    input  in_valid, req, out_ready,
    output in_ready, out_valid, y, out_last, cnt, zero_err
  );

  modport master (
    output in_valid, req, out_ready,
    input  in_ready, out_valid, y, out_last, cnt, zero_err
  );

endinterface

// File: rtl/enc_8_3_stream_prio_enc_n.sv
// rtl/enc_8_3_stream_prio_enc_n.sv - combinational highest-index priority encoder
module prio_enc_n #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic [N-1:0]  i_vec,
  output logic [CW-1:0] o_idx,
  output logic          o_any
);

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx = CW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc_8_3_stream.sv
// rtl/enc_8_3_stream.sv - latches a request vector and streams out the index of each set bit, highest first
module enc_8_3_stream
  import enc_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  enc_8_3_stream_if.slave  bus
);

  localparam int CW = $clog2(N);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_pending;
  logic [N-1:0]  w_pending_nxt;
  logic [CW:0]   r_cnt;
  logic [CW:0]   w_cnt_nxt;
  logic          r_zero_err;
  logic          w_zero_err_nxt;

  logic [CW-1:0] w_idx;
  logic          w_any;
  logic          w_last;
  logic          w_in_ready;
  logic          w_accept;

  prio_enc_n #(.N(N)) u_prio (
    .i_vec (r_pending),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_last     = (popcount(32'(r_pending)) == 1);
  // rst_n gates ready so nothing looks acceptable during the reset cycle.
  assign w_in_ready = rst_n && en && (r_state == IDLE);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_cnt_nxt      = r_cnt;
    w_zero_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.req != '0) begin
            w_pending_nxt = bus.req;
            w_cnt_nxt     = (CW+1)'(popcount(32'(bus.req)));
            w_state_nxt   = BUSY;
          end else begin
            w_zero_err_nxt = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.out_ready && w_any) begin
          w_pending_nxt[w_idx] = 1'b0;
          if (w_last) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_cnt      <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_cnt      <= w_cnt_nxt;
      r_zero_err <= w_zero_err_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == BUSY);
  assign bus.y         = w_idx;
  assign bus.out_last  = (r_state == BUSY) && w_last;
  assign bus.cnt       = r_cnt;
  assign bus.zero_err  = r_zero_err;

endmodule

// File: tb/tb_enc_8_3_stream.sv
// tb/tb_enc_8_3_stream.sv - randomized and directed bench with a queue-based reference model
module tb_enc_8_3_stream;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  // Model: the list of codes still owed for the latched vector, highest first.
  int          m_q[$];
  logic [3:0]  m_cnt  = '0;
  logic        m_zerr = 1'b0;
  int          m_acc  = 0;

  int          q_got[$];
  int          q_last[$];
  int          q_cnt[$];
  int          n_zerr = 0;

  enc_8_3_stream_if #(.N(8)) bus ();

  enc_8_3_stream #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check({nm, " idle_timeout"}, 32'(done), 32'd1);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt  = '0;
      m_zerr = 1'b0;
    end else begin
      m_zerr = 1'b0;
      if (m_q.size() != 0) begin
        if (bus.out_ready) void'(m_q.pop_front());
      end else if (en && bus.in_valid) begin
        m_acc++;
        if (bus.req == 8'h00) begin
          m_zerr = 1'b1;
        end else begin
          for (int b = 7; b >= 0; b--) if (bus.req[b]) m_q.push_back(b);
          m_cnt = 4'($countones(bus.req));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(bus.in_ready), 32'(rst_n && en && (m_q.size() == 0)));
      check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      check("zero_err", 32'(bus.zero_err), 32'(m_zerr));
      if (m_q.size() != 0) begin
        check("y", 32'(bus.y), 32'(m_q[0]));
        check("out_last", 32'(bus.out_last), 32'(m_q.size() == 1));
        check("cnt", 32'(bus.cnt), 32'(m_cnt));
        if (bus.out_ready && rst_n) begin
          logic [7:0] dec;
          logic [7:0] one_hot;
          dec     = 8'(1) << bus.y;
          one_hot = 8'(1) << m_q[0];
          check("decode_back", 32'(dec), 32'(one_hot));
        end
      end
      if (bus.out_valid && bus.out_ready && rst_n) begin
        q_got.push_back(int'(bus.y));
        q_last.push_back(int'(bus.out_last));
        q_cnt.push_back(int'(bus.cnt));
      end
      if (bus.zero_err) n_zerr++;
    end
  end

  task automatic clear_obs();
    q_got.delete();
    q_last.delete();
    q_cnt.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int         acc0;
    int         j;
    bit         ok;

    rst_n         = 1'b0;
    en            = 1'b0;
    bus.in_valid  = 1'b0;
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;
    cyc();
    chk_en = 1'b1;
    en     = 1'b1;
    @(negedge clk);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst y", 32'(bus.y), 32'd0);
    check("rst out_last", 32'(bus.out_last), 32'd0);
    check("rst cnt", 32'(bus.cnt), 32'd0);
    check("rst zero_err", 32'(bus.zero_err), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Vector 0xA4 streams 7,5,2.
    clear_obs();
    bus.in_valid = 1'b1; bus.req = 8'hA4; bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t1 in_ready_low", 32'(bus.in_ready), 32'd0);
    check("t1 cnt", 32'(bus.cnt), 32'd3);
    wait_idle("t1");
    check("t1 ncodes", 32'(q_got.size()), 32'd3);
    if (q_got.size() == 3) begin
      check("t1 c0", 32'(q_got[0]), 32'd7);
      check("t1 c1", 32'(q_got[1]), 32'd5);
      check("t1 c2", 32'(q_got[2]), 32'd2);
      check("t1 last0", 32'(q_last[0]), 32'd0);
      check("t1 last1", 32'(q_last[1]), 32'd0);
      check("t1 last2", 32'(q_last[2]), 32'd1);
    end
    check("t1 in_ready_back", 32'(bus.in_ready), 32'd1);

    // All-zero vector pulses zero_err once.
    clear_obs();
    cyc();
    n_zerr = 0;
    bus.in_valid = 1'b1; bus.req = 8'h00;
    cyc();
    bus.in_valid = 1'b0;
    repeat (4) cyc();
    check("t2 zerr_pulses", 32'(n_zerr), 32'd1);
    check("t2 ncodes", 32'(q_got.size()), 32'd0);

    // 0xFF with out_ready 1,0,0,1 pattern.
    clear_obs();
    bus.in_valid = 1'b1; bus.req = 8'hFF;
    cyc();
    bus.in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (m_q.size() == 0) begin ok = 1'b1; break; end
      bus.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      cyc();
    end
    check("t3 timeout", 32'(ok), 32'd1);
    bus.out_ready = 1'b1;
    check("t3 ncodes", 32'(q_got.size()), 32'd8);
    for (int i = 0; i < q_got.size() && i < 8; i++) begin
      check("t3 code", 32'(q_got[i]), 32'(7 - i));
      check("t3 cnt", 32'(q_cnt[i]), 32'd8);
    end

    // en low blocks acceptance; raising en releases one code.
    cyc();
    clear_obs();
    en = 1'b0; bus.in_valid = 1'b1; bus.req = 8'h10;
    repeat (4) cyc();
    check("t4 blocked", 32'(q_got.size()), 32'd0);
    en = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    wait_idle("t4");
    check("t4 ncodes", 32'(q_got.size()), 32'd1);
    if (q_got.size() == 1) begin
      check("t4 y", 32'(q_got[0]), 32'd4);
      check("t4 last", 32'(q_last[0]), 32'd1);
      check("t4 cnt", 32'(q_cnt[0]), 32'd1);
    end

    // Reset after the first code of 0xC3 discards the rest.
    cyc();
    clear_obs();
    bus.in_valid = 1'b1; bus.req = 8'hC3;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5 out_valid", 32'(bus.out_valid), 32'd0);
    check("t5 cnt", 32'(bus.cnt), 32'd0);
    repeat (4) cyc();
    check("t5 ncodes", 32'(q_got.size()), 32'd1);
    if (q_got.size() >= 1) check("t5 c0", 32'(q_got[0]), 32'd7);
    bus.in_valid = 1'b1; bus.req = 8'h01;
    cyc();
    bus.in_valid = 1'b0;
    wait_idle("t5b");
    check("t5b ncodes", 32'(q_got.size()), 32'd2);
    if (q_got.size() == 2) check("t5b y", 32'(q_got[1]), 32'd0);

    // Random vectors with random en and out_ready.
    for (int n = 0; n < 5; n++) begin
      cyc();
      clear_obs();
      v    = 8'($urandom_range(1, 255));
      acc0 = m_acc;
      bus.in_valid = 1'b1; bus.req = v;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        en            = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        cyc();
        if (m_acc != acc0) begin ok = 1'b1; break; end
      end
      bus.in_valid = 1'b0;
      check("rnd accept_timeout", 32'(ok), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (m_q.size() == 0) begin ok = 1'b1; break; end
        en            = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        cyc();
      end
      check("rnd drain_timeout", 32'(ok), 32'd1);
      bus.out_ready = 1'b1;
      en = 1'b1;
      check("rnd ncodes", 32'(q_got.size()), 32'($countones(v)));
      j = 0;
      for (int b = 7; b >= 0; b--) begin
        if (v[b]) begin
          if (j < q_got.size()) check("rnd code", 32'(q_got[j]), 32'(b));
          j++;
        end
      end
    end

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
